// File: rtl/axonerve_kvs_ctrl_slave_if.sv
// AXI4-Lite control-port bundle between the host platform and the KVS kernel control slave.
// Single 32-bit data lane; the address width is a parameter.
interface axonerve_kvs_ctrl_slave_if #(
    parameter int ADDR_W = 12
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axonerve_kvs_ctrl_slave.sv
// Host control registers for the KVS kernel: ap_start/ap_done/ap_idle handshake, interrupt, scalar args.
// Latency: register write visible 1 cycle after the w handshake; rvalid 1 cycle after the ar handshake.
// Backpressure: each channel holds its response (bvalid/rvalid) until the host accepts it.
module axonerve_kvs_ctrl_slave #(
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    axonerve_kvs_ctrl_slave_if.slave        s_axi_control,
    output logic                            interrupt,
    output logic                            ap_start,
    input  logic                            ap_idle,
    input  logic                            ap_done,
    output logic [31:0]                     data_num,
    output logic [63:0]                     axi00_ptr0
);
    localparam logic [1:0] WIDLE = 2'd0;
    localparam logic [1:0] WDATA = 2'd1;
    localparam logic [1:0] WRESP = 2'd2;
    localparam logic [0:0] RIDLE = 1'b0;
    localparam logic [0:0] RDATA = 1'b1;

    localparam logic [5:0] A_CTRL  = 6'h00;
    localparam logic [5:0] A_GIE   = 6'h01;
    localparam logic [5:0] A_IER   = 6'h02;
    localparam logic [5:0] A_ISR   = 6'h03;
    localparam logic [5:0] A_NUM   = 6'h04;
    localparam logic [5:0] A_PTRLO = 6'h06;
    localparam logic [5:0] A_PTRHI = 6'h07;

    logic [1:0]  wstate_q, wstate_d;
    logic [0:0]  rstate_q, rstate_d;
    logic [5:0]  waddr_q, waddr_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic        ap_start_q, ap_start_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;
    logic        auto_restart_q, auto_restart_d;
    logic        gie_q, gie_d;
    logic        ier_q, ier_d;
    logic        isr_q, isr_d;
    logic        interrupt_q, interrupt_d;
    logic [31:0] data_num_q, data_num_d;
    logic [63:0] ptr0_q, ptr0_d;

    logic        wr_en;
    logic        rd_en;
    logic [5:0]  raddr;
    logic [31:0] rd_mux;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{s_axi_control.awaddr[C_S_AXI_ADDR_WIDTH-1:8], s_axi_control.awaddr[1:0],
                                s_axi_control.araddr[C_S_AXI_ADDR_WIDTH-1:8], s_axi_control.araddr[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) m[8*b +: 8] = d[8*b +: 8];
        end
        return m;
    endfunction

    assign wr_en = (wstate_q == WDATA) && s_axi_control.wvalid;
    assign rd_en = (rstate_q == RIDLE) && s_axi_control.arvalid;
    assign raddr = s_axi_control.araddr[7:2];

    always_comb begin
        rd_mux = 32'h0;
        case (raddr)
            A_CTRL:  rd_mux = {24'h0, auto_restart_q, 3'b000, ready_q, ap_idle, done_q, ap_start_q};
            A_GIE:   rd_mux = {31'h0, gie_q};
            A_IER:   rd_mux = {31'h0, ier_q};
            A_ISR:   rd_mux = {31'h0, isr_q};
            A_NUM:   rd_mux = data_num_q;
            A_PTRLO: rd_mux = ptr0_q[31:0];
            A_PTRHI: rd_mux = ptr0_q[63:32];
            default: rd_mux = 32'h0;
        endcase
    end

    always_comb begin
        wstate_d = wstate_q;
        waddr_d  = waddr_q;
        case (wstate_q)
            WIDLE: if (s_axi_control.awvalid) begin
                waddr_d  = s_axi_control.awaddr[7:2];
                wstate_d = WDATA;
            end
            WDATA: if (s_axi_control.wvalid) wstate_d = WRESP;
            WRESP: if (s_axi_control.bready) wstate_d = WIDLE;
            default: wstate_d = WIDLE;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        case (rstate_q)
            RIDLE: if (s_axi_control.arvalid) begin
                rdata_d  = rd_mux;
                rstate_d = RDATA;
            end
            RDATA: if (s_axi_control.rready) rstate_d = RIDLE;
            default: rstate_d = RIDLE;
        endcase
    end

    // Register file; status sets take priority over same-cycle clears and toggles.
    always_comb begin
        ap_start_d     = ap_start_q;
        done_d         = done_q;
        ready_d        = ready_q;
        auto_restart_d = auto_restart_q;
        gie_d          = gie_q;
        ier_d          = ier_q;
        isr_d          = isr_q;
        data_num_d     = data_num_q;
        ptr0_d         = ptr0_q;

        if (ap_done && !auto_restart_q) ap_start_d = 1'b0;
        if (rd_en && raddr == A_CTRL) begin
            done_d  = 1'b0;
            ready_d = 1'b0;
        end
        if (ap_done) begin
            done_d  = 1'b1;
            ready_d = 1'b1;
        end

        if (wr_en) begin
            case (waddr_q)
                A_CTRL: if (s_axi_control.wstrb[0]) begin
                    if (s_axi_control.wdata[0]) ap_start_d = 1'b1;
                    auto_restart_d = s_axi_control.wdata[7];
                end
                A_GIE:   if (s_axi_control.wstrb[0]) gie_d = s_axi_control.wdata[0];
                A_IER:   if (s_axi_control.wstrb[0]) ier_d = s_axi_control.wdata[0];
                A_ISR:   if (s_axi_control.wstrb[0] && s_axi_control.wdata[0]) isr_d = ~isr_q;
                A_NUM:   data_num_d = merge(data_num_q, s_axi_control.wdata, s_axi_control.wstrb);
                A_PTRLO: ptr0_d[31:0] = merge(ptr0_q[31:0], s_axi_control.wdata, s_axi_control.wstrb);
                A_PTRHI: ptr0_d[63:32] = merge(ptr0_q[63:32], s_axi_control.wdata, s_axi_control.wstrb);
                default: ;
            endcase
        end

        if (ap_done && ier_q) isr_d = 1'b1;
        interrupt_d = gie_d & ier_d & isr_d;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wstate_q       <= WIDLE;
            rstate_q       <= RIDLE;
            waddr_q        <= 6'h0;
            rdata_q        <= '0;
            ap_start_q     <= 1'b0;
            done_q         <= 1'b0;
            ready_q        <= 1'b0;
            auto_restart_q <= 1'b0;
            gie_q          <= 1'b0;
            ier_q          <= 1'b0;
            isr_q          <= 1'b0;
            interrupt_q    <= 1'b0;
            data_num_q     <= 32'h0;
            ptr0_q         <= 64'h0;
        end else begin
            wstate_q       <= wstate_d;
            rstate_q       <= rstate_d;
            waddr_q        <= waddr_d;
            rdata_q        <= rdata_d;
            ap_start_q     <= ap_start_d;
            done_q         <= done_d;
            ready_q        <= ready_d;
            auto_restart_q <= auto_restart_d;
            gie_q          <= gie_d;
            ier_q          <= ier_d;
            isr_q          <= isr_d;
            interrupt_q    <= interrupt_d;
            data_num_q     <= data_num_d;
            ptr0_q         <= ptr0_d;
        end
    end

    assign s_axi_control.awready = (wstate_q == WIDLE);
    assign s_axi_control.wready  = (wstate_q == WDATA);
    assign s_axi_control.bvalid  = (wstate_q == WRESP);
    assign s_axi_control.bresp   = 2'b00;
    assign s_axi_control.arready = (rstate_q == RIDLE);
    assign s_axi_control.rvalid  = (rstate_q == RDATA);
    assign s_axi_control.rdata   = rdata_q;
    assign s_axi_control.rresp   = 2'b00;

    assign interrupt  = interrupt_q;
    assign ap_start   = ap_start_q;
    assign data_num   = data_num_q;
    assign axi00_ptr0 = ptr0_q;
endmodule

// File: tb/tb_axonerve_kvs_ctrl_slave.sv
// Bench for the KVS control slave: read/write responses are scored from queues by a negedge monitor.
module tb_axonerve_kvs_ctrl_slave;
    logic        ap_clk;
    logic        ap_rst_n;
    logic        interrupt;
    logic        ap_start;
    logic        ap_idle;
    logic        ap_done;
    logic [31:0] data_num;
    logic [63:0] axi00_ptr0;

    int total = 0;
    int bad   = 0;
    logic [31:0] rd_q[$];
    logic [1:0]  b_q[$];

    axonerve_kvs_ctrl_slave_if #(.ADDR_W(12)) axi();

    axonerve_kvs_ctrl_slave #(.C_S_AXI_ADDR_WIDTH(12), .C_S_AXI_DATA_WIDTH(32)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_axi_control(axi),
        .interrupt(interrupt), .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done),
        .data_num(data_num), .axi00_ptr0(axi00_ptr0)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: score every accepted read and write response against the queued expectation.
    always @(negedge ap_clk) begin
        if (ap_rst_n && axi.rvalid && axi.rready) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got %0h want none", axi.rdata);
            end else begin
                logic [31:0] e;
                e = rd_q.pop_front();
                if (axi.rdata !== e || axi.rresp !== 2'b00) begin
                    bad++;
                    $display("FAIL rdata: got %0h/%0h want %0h/0", axi.rdata, axi.rresp, e);
                end
            end
        end
        if (ap_rst_n && axi.bvalid && axi.bready) begin
            total++;
            if (b_q.size() == 0) begin
                bad++;
                $display("FAIL b_unexpected: got %0h want none", axi.bresp);
            end else begin
                logic [1:0] e;
                e = b_q.pop_front();
                if (axi.bresp !== e) begin
                    bad++;
                    $display("FAIL bresp: got %0h want %0h", axi.bresp, e);
                end
            end
        end
    end

    function automatic logic sig(input int which);
        case (which)
            0: return axi.awready;
            1: return axi.wready;
            2: return axi.bvalid;
            3: return axi.arready;
            default: return axi.rvalid;
        endcase
    endfunction

    task automatic wait_hi(input int which, input string name);
        int n = 0;
        while (!sig(which) && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL timeout_%s: got 0 want 1", name);
        end
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge ap_clk);
        axi.awaddr = a; axi.awvalid = 1'b1;
        axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
        b_q.push_back(2'b00);
        wait_hi(0, "awready");
        @(negedge ap_clk);
        axi.awvalid = 1'b0;
        wait_hi(1, "wready");
        @(negedge ap_clk);
        axi.wvalid = 1'b0;
        wait_hi(2, "bvalid");
        @(negedge ap_clk);
    endtask

    task automatic axi_read(input logic [11:0] a, input logic [31:0] e);
        @(negedge ap_clk);
        axi.araddr = a; axi.arvalid = 1'b1;
        rd_q.push_back(e);
        wait_hi(3, "arready");
        @(negedge ap_clk);
        axi.arvalid = 1'b0;
        wait_hi(4, "rvalid");
        @(negedge ap_clk);
    endtask

    task automatic pulse_done();
        @(negedge ap_clk);
        ap_done = 1'b1;
        @(negedge ap_clk);
        ap_done = 1'b0;
    endtask

    initial begin
        ap_rst_n = 1'b0; ap_idle = 1'b1; ap_done = 1'b0;
        axi.awvalid = 1'b0; axi.awaddr = '0; axi.wvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0;
        axi.bready = 1'b1; axi.arvalid = 1'b0; axi.araddr = '0; axi.rready = 1'b1;
        repeat (3) @(negedge ap_clk);
        chk("rst_awready", axi.awready, 1);
        chk("rst_arready", axi.arready, 1);
        chk("rst_wready", axi.wready, 0);
        chk("rst_bvalid", axi.bvalid, 0);
        chk("rst_rvalid", axi.rvalid, 0);
        chk("rst_rdata", axi.rdata, 0);
        chk("rst_irq", interrupt, 0);
        chk("rst_start", ap_start, 0);
        ap_rst_n = 1'b1;

        axi_read(12'h000, 32'h0000_0004);

        axi_write(12'h010, 32'h0000_4000, 4'hF);
        axi_write(12'h018, 32'h89AB_CDEF, 4'hF);
        axi_write(12'h01C, 32'h0123_4567, 4'hF);
        chk("data_num", data_num, 64'h4000);
        chk("ptr0", axi00_ptr0, 64'h0123_4567_89AB_CDEF);
        axi_write(12'h018, 32'h0000_00FF, 4'b0001);
        chk("ptr0_strb", axi00_ptr0, 64'h0123_4567_89AB_CDFF);
        axi_write(12'h014, 32'hDEAD_BEEF, 4'hF);
        axi_read(12'h014, 32'h0);
        axi_read(12'h018, 32'h89AB_CDFF);
        axi_read(12'h01F, 32'h0123_4567);

        ap_idle = 1'b0;
        axi_write(12'h000, 32'h1, 4'hF);
        chk("start_set", ap_start, 1);
        pulse_done();
        chk("start_clr", ap_start, 0);
        axi_read(12'h000, 32'h0000_000A);
        axi_read(12'h000, 32'h0000_0000);

        axi_write(12'h004, 32'h1, 4'hF);
        axi_write(12'h008, 32'h1, 4'hF);
        axi_write(12'h000, 32'h1, 4'hF);
        chk("irq_before", interrupt, 0);
        pulse_done();
        chk("irq_set", interrupt, 1);
        axi_read(12'h00C, 32'h1);
        axi_write(12'h00C, 32'h1, 4'hF);
        chk("irq_clr", interrupt, 0);
        axi_read(12'h00C, 32'h0);
        axi_read(12'h000, 32'h0000_000A);

        axi_write(12'h000, 32'h81, 4'hF);
        for (int i = 0; i < 3; i++) begin
            pulse_done();
            chk("auto_hold", ap_start, 1);
        end
        axi_read(12'h000, 32'h0000_008B);
        axi_write(12'h000, 32'h0, 4'hF);
        chk("auto_off_hold", ap_start, 1);
        pulse_done();
        chk("auto_off_clr", ap_start, 0);
        axi_read(12'h000, 32'h0000_000A);

        // Write response stall, then reset while the response is still pending.
        axi.bready = 1'b0;
        @(negedge ap_clk);
        axi.awaddr = 12'h010; axi.awvalid = 1'b1;
        axi.wdata = 32'h1234; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        wait_hi(0, "awready");
        @(negedge ap_clk);
        axi.awvalid = 1'b0;
        wait_hi(1, "wready");
        @(negedge ap_clk);
        axi.wvalid = 1'b0;
        repeat (5) @(negedge ap_clk);
        chk("stall_bvalid", axi.bvalid, 1);
        chk("stall_awready", axi.awready, 0);
        chk("stall_data", data_num, 64'h1234);
        ap_idle = 1'b1;
        ap_rst_n = 1'b0;
        #1;
        chk("midrst_bvalid", axi.bvalid, 0);
        chk("midrst_data", data_num, 0);
        chk("midrst_ptr", axi00_ptr0, 0);
        chk("midrst_awready", axi.awready, 1);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        axi.bready = 1'b1;
        axi_read(12'h000, 32'h0000_0004);

        // Data presented before its address must wait.
        @(negedge ap_clk);
        axi.wdata = 32'h77; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        repeat (3) @(negedge ap_clk);
        chk("early_w_wready", axi.wready, 0);
        chk("early_w_data", data_num, 0);
        axi.awaddr = 12'h010; axi.awvalid = 1'b1;
        b_q.push_back(2'b00);
        wait_hi(0, "awready");
        @(negedge ap_clk);
        axi.awvalid = 1'b0;
        chk("late_aw_wready", axi.wready, 1);
        @(negedge ap_clk);
        axi.wvalid = 1'b0;
        chk("late_aw_data", data_num, 64'h77);
        wait_hi(2, "bvalid");
        @(negedge ap_clk);

        repeat (3) @(negedge ap_clk);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("b_q_empty", b_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
